// File: rtl/plantard_arbiter.sv
// Round-robin arbiter that shares one Plantard reducer among N requesters and queues results in issue order.
// Optional build macro PLANTARD_ARB_STATS_EN adds per-requester saturating grant counters on stat_grants.
module plantard_arbiter #(
   parameter int W     = 32,
   parameter int N     = 4,
   parameter int LAT   = 3,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           req_valid,
   input  logic [N*2*W-1:0]       req_a,
   output logic [N-1:0]           req_ready,
   output logic [2*W-1:0]         red_a,
   input  logic [W-1:0]           red_t,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [W-1:0]           rsp_t,
   output logic [$clog2(N)-1:0]   rsp_id
`ifdef PLANTARD_ARB_STATS_EN
   ,
   output logic [N*16-1:0]        stat_grants
`endif
);

   localparam int IDW = $clog2(N);
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;

   logic [IDW-1:0]          ptr_q, ptr_d;
   logic [IDW-1:0]          grantIdx, candIdx;
   logic                    grantAny;
   logic [N-1:0]            grantVec;
   int                      cand;
   logic [CW-1:0]           credit_q, credit_d;
   logic [2*W-1:0]          redA_q, redA_d;
   logic [LAT-1:0]          tagValid_q, tagValid_d;
   logic [LAT-1:0][IDW-1:0] tagId_q, tagId_d;
   logic [W-1:0]            memT_q [DEPTH];
   logic [IDW-1:0]          memId_q [DEPTH];
   logic [PW-1:0]           wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    push, pop;

   // Credits bound in-flight plus queued results to DEPTH, so a grant can never overflow the FIFO.
   always_comb begin
      grantAny = 1'b0;
      grantIdx = '0;
      grantVec = '0;
      cand     = 0;
      candIdx  = '0;
      if (!rst && credit_q != '0) begin
         for (int k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) cand = cand - N;
            candIdx = IDW'(cand);
            if (!grantAny && req_valid[candIdx]) begin
               grantAny = 1'b1;
               grantIdx = candIdx;
            end
         end
      end
      if (grantAny) grantVec[grantIdx] = 1'b1;
   end

   assign rsp_valid = (count_q != '0);

   always_comb begin
      pop  = rsp_valid & rsp_ready;
      push = tagValid_q[LAT-1];
      ptr_d  = ptr_q;
      redA_d = redA_q;
      if (grantAny) begin
         ptr_d  = (grantIdx == IDW'(N-1)) ? '0 : grantIdx + 1'b1;
         redA_d = req_a[grantIdx*2*W +: 2*W];
      end
      credit_d = credit_q;
      case ({grantAny, pop})
         2'b10:   credit_d = credit_q - 1'b1;
         2'b01:   credit_d = credit_q + 1'b1;
         default: credit_d = credit_q;
      endcase
      tagValid_d    = '0;
      tagId_d       = '0;
      tagValid_d[0] = grantAny;
      tagId_d[0]    = grantIdx;
      for (int i = 1; i < LAT; i++) begin
         tagValid_d[i] = tagValid_q[i-1];
         tagId_d[i]    = tagId_q[i-1];
      end
      wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
      rdPtr_d = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Clearing the tag valids on reset is what makes late reducer results harmless.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         credit_q   <= CW'(DEPTH);
         redA_q     <= '0;
         tagValid_q <= '0;
         tagId_q    <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
      end else begin
         ptr_q      <= ptr_d;
         credit_q   <= credit_d;
         redA_q     <= redA_d;
         tagValid_q <= tagValid_d;
         tagId_q    <= tagId_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         memT_q[wrPtr_q]  <= red_t;
         memId_q[wrPtr_q] <= tagId_q[LAT-1];
      end
   end

   assign req_ready = grantVec;
   assign red_a     = redA_q;
   assign rsp_t     = memT_q[rdPtr_q];
   assign rsp_id    = memId_q[rdPtr_q];

`ifdef PLANTARD_ARB_STATS_EN
   logic [N-1:0][15:0] statCnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         statCnt_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (grantVec[i] && statCnt_q[i] != 16'hFFFF) statCnt_q[i] <= statCnt_q[i] + 16'd1;
         end
      end
   end

   assign stat_grants = statCnt_q;
`endif

endmodule
